// File: rtl/axi4_burst_addr_gen.sv
// AXI4 burst address generator: one command in, one addr/strobe beat per handshake; first beat 1 cycle after accept.
// Backpressure: beat outputs hold while beat_ready is low; cmd_ready only in IDLE, re-raised one cycle after the burst ends.
module axi4_burst_addr_gen #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int STROBE_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [7:0]               cmd_len,
    input  logic [2:0]               cmd_size,
    input  logic [1:0]               cmd_burst,
    output logic                     beat_valid,
    input  logic                     beat_ready,
    output logic [ADDRESS_WIDTH-1:0] beat_addr,
    output logic [STROBE_WIDTH-1:0]  beat_strb,
    output logic [7:0]               beat_idx,
    output logic                     beat_last,
    output logic                     cmd_err
);
    localparam int AW      = ADDRESS_WIDTH;
    localparam int LOG2_SW = $clog2(STROBE_WIDTH);

    localparam logic [1:0] B_FIXED = 2'b00;
    localparam logic [1:0] B_INCR  = 2'b01;
    localparam logic [1:0] B_WRAP  = 2'b10;
    localparam logic [1:0] B_RSVD  = 2'b11;

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   cmd_err_q, cmd_err_d;
    logic                   beat_valid_q, beat_valid_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [STROBE_WIDTH-1:0] strb_q, strb_d;
    logic [7:0]             idx_q, idx_d;
    logic                   last_q, last_d;
    logic [7:0]             len_q, len_d;
    logic [2:0]             size_q, size_d;
    logic [1:0]             burst_q, burst_d;
    logic [AW-1:0]          lower_q, lower_d;
    logic [AW-1:0]          wrap_mask_q, wrap_mask_d;

    logic                   cmd_accept;
    logic                   cmd_illegal;
    logic [AW-1:0]          c_sz, c_aligned, c_bytes, c_last_byte;
    logic                   wrap_len_ok;
    logic [AW-1:0]          b_sz, next_addr;

    // Lanes from the byte offset of a up to the end of its size-aligned container.
    function automatic logic [STROBE_WIDTH-1:0] calc_strb(input logic [AW-1:0] a, input logic [2:0] s);
        logic [AW-1:0] sz, al, lo, hi;
        calc_strb = '0;
        sz = AW'(1) << s;
        al = a & ~(sz - AW'(1));
        lo = a % AW'(STROBE_WIDTH);
        hi = (al % AW'(STROBE_WIDTH)) + sz - AW'(1);
        for (int i = 0; i < STROBE_WIDTH; i++) begin
            calc_strb[i] = (AW'(i) >= lo) && (AW'(i) <= hi);
        end
    endfunction

    assign cmd_accept = cmd_valid && cmd_ready_q;

    always_comb begin
        c_sz        = AW'(1) << cmd_size;
        c_aligned   = cmd_addr & ~(c_sz - AW'(1));
        c_bytes     = (AW'(cmd_len) + AW'(1)) << cmd_size;
        c_last_byte = c_aligned + c_bytes - AW'(1);
        wrap_len_ok = (cmd_len == 8'd1) || (cmd_len == 8'd3) || (cmd_len == 8'd7) || (cmd_len == 8'd15);
        cmd_illegal = 1'b0;
        if (int'(cmd_size) > LOG2_SW)                                  cmd_illegal = 1'b1;
        if (cmd_burst == B_RSVD)                                       cmd_illegal = 1'b1;
        if (cmd_burst == B_FIXED && cmd_len > 8'd15)                   cmd_illegal = 1'b1;
        if (cmd_burst == B_WRAP && (!wrap_len_ok || c_aligned != cmd_addr)) cmd_illegal = 1'b1;
        if (cmd_burst == B_INCR && c_last_byte[AW-1:12] != cmd_addr[AW-1:12]) cmd_illegal = 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        cmd_err_d    = 1'b0;
        cmd_ready_d  = (state_q == IDLE) && !cmd_accept;
        beat_valid_d = beat_valid_q;
        addr_d       = addr_q;
        strb_d       = strb_q;
        idx_d        = idx_q;
        last_d       = last_q;
        len_d        = len_q;
        size_d       = size_q;
        burst_d      = burst_q;
        lower_d      = lower_q;
        wrap_mask_d  = wrap_mask_q;

        b_sz = AW'(1) << size_q;
        case (burst_q)
            B_FIXED: next_addr = addr_q;
            B_WRAP:  next_addr = lower_q | ((addr_q + b_sz) & wrap_mask_q);
            default: next_addr = (addr_q & ~(b_sz - AW'(1))) + b_sz;
        endcase

        case (state_q)
            IDLE: begin
                if (cmd_accept) begin
                    if (cmd_illegal) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        state_d      = BURST;
                        beat_valid_d = 1'b1;
                        addr_d       = cmd_addr;
                        strb_d       = calc_strb(cmd_addr, cmd_size);
                        idx_d        = 8'd0;
                        last_d       = (cmd_len == 8'd0);
                        len_d        = cmd_len;
                        size_d       = cmd_size;
                        burst_d      = cmd_burst;
                        wrap_mask_d  = c_bytes - AW'(1);
                        lower_d      = cmd_addr & ~(c_bytes - AW'(1));
                    end
                end
            end
            BURST: begin
                if (beat_ready) begin
                    if (last_q) begin
                        state_d      = IDLE;
                        beat_valid_d = 1'b0;
                        last_d       = 1'b0;
                    end else begin
                        addr_d = next_addr;
                        strb_d = calc_strb(next_addr, size_q);
                        idx_d  = idx_q + 8'd1;
                        last_d = ((idx_q + 8'd1) == len_q);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= IDLE;
            cmd_ready_q  <= 1'b0;
            cmd_err_q    <= 1'b0;
            beat_valid_q <= 1'b0;
            addr_q       <= '0;
            strb_q       <= '0;
            idx_q        <= '0;
            last_q       <= 1'b0;
            len_q        <= '0;
            size_q       <= '0;
            burst_q      <= '0;
            lower_q      <= '0;
            wrap_mask_q  <= '0;
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            cmd_err_q    <= cmd_err_d;
            beat_valid_q <= beat_valid_d;
            addr_q       <= addr_d;
            strb_q       <= strb_d;
            idx_q        <= idx_d;
            last_q       <= last_d;
            len_q        <= len_d;
            size_q       <= size_d;
            burst_q      <= burst_d;
            lower_q      <= lower_d;
            wrap_mask_q  <= wrap_mask_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign cmd_err    = cmd_err_q;
    assign beat_valid = beat_valid_q;
    assign beat_addr  = addr_q;
    assign beat_strb  = strb_q;
    assign beat_idx   = idx_q;
    assign beat_last  = last_q;

endmodule

// File: tb/tb_axi4_burst_addr_gen.sv
// Directed bench for axi4_burst_addr_gen with DATA_WIDTH = 32; inputs driven and outputs sampled 1ns after each rising edge.
module tb_axi4_burst_addr_gen;
    logic        aclk = 1'b0;
    logic        areset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic        beat_valid;
    logic        beat_ready;
    logic [31:0] beat_addr;
    logic [3:0]  beat_strb;
    logic [7:0]  beat_idx;
    logic        beat_last;
    logic        cmd_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    axi4_burst_addr_gen #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
        .aclk       (aclk),
        .areset     (areset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .cmd_size   (cmd_size),
        .cmd_burst  (cmd_burst),
        .beat_valid (beat_valid),
        .beat_ready (beat_ready),
        .beat_addr  (beat_addr),
        .beat_strb  (beat_strb),
        .beat_idx   (beat_idx),
        .beat_last  (beat_last),
        .cmd_err    (cmd_err)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
        cyc++;
    endtask

    // Waits (bounded) for cmd_ready, then presents one command for exactly one cycle.
    task automatic send_cmd(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                            input logic [1:0] b, output int acc_cyc);
        for (int i = 0; i < 40 && cmd_ready !== 1'b1; i++) tick();
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd_ready_timeout: got %b expected 1", cmd_ready);
        end
        cmd_addr  = a;
        cmd_len   = l;
        cmd_size  = s;
        cmd_burst = b;
        cmd_valid = 1'b1;
        acc_cyc   = cyc;
        tick();
        cmd_valid = 1'b0;
        cmd_addr  = 32'hDEAD_BEEF;
        cmd_len   = 8'hFF;
        cmd_size  = 3'd7;
        cmd_burst = 2'b11;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({cmd_ready, beat_valid, beat_last, cmd_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000", {cmd_ready, beat_valid, beat_last, cmd_err});
        end
        n_checks++;
        if (beat_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_addr: got %h expected 00000000", beat_addr);
        end
        n_checks++;
        if ({beat_strb, beat_idx} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_strb_idx: got %h expected 000", {beat_strb, beat_idx});
        end
        areset = 1'b0;
        tick();
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_incr();
        logic [31:0] ea [4];
        logic [3:0]  es [4];
        int acc;
        ea = '{32'h1002, 32'h1004, 32'h1008, 32'h100C};
        es = '{4'hC, 4'hF, 4'hF, 4'hF};
        beat_ready = 1'b1;
        send_cmd(32'h1002, 8'd3, 3'd2, 2'b01, acc);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (beat_valid !== 1'b1 || beat_addr !== ea[i] || beat_strb !== es[i]) begin
                n_fail++;
                $display("FAIL incr_beat%0d: got v=%b a=%h s=%h expected v=1 a=%h s=%h",
                         i, beat_valid, beat_addr, beat_strb, ea[i], es[i]);
            end
            n_checks++;
            if (beat_idx !== 8'(i) || beat_last !== (i == 3)) begin
                n_fail++;
                $display("FAIL incr_idx_last%0d: got idx=%0d last=%b expected idx=%0d last=%b",
                         i, beat_idx, beat_last, i, (i == 3));
            end
            tick();
        end
        n_checks++;
        if (beat_valid !== 1'b0 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL incr_end_idle: got v=%b rdy=%b expected v=0 rdy=0", beat_valid, cmd_ready);
        end
        tick();
        n_checks++;
        if (cmd_ready !== 1'b1 || beat_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL incr_ready_after: got rdy=%b v=%b expected rdy=1 v=0", cmd_ready, beat_valid);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] ea [4];
        int acc;
        ea = '{32'h38, 32'h3C, 32'h30, 32'h34};
        beat_ready = 1'b1;
        send_cmd(32'h38, 8'd3, 3'd2, 2'b10, acc);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (beat_valid !== 1'b1 || beat_addr !== ea[i] || beat_strb !== 4'hF || beat_last !== (i == 3)) begin
                n_fail++;
                $display("FAIL wrap_beat%0d: got v=%b a=%h s=%h l=%b expected v=1 a=%h s=f l=%b",
                         i, beat_valid, beat_addr, beat_strb, beat_last, ea[i], (i == 3));
            end
            tick();
        end
    endtask

    task automatic test_fixed();
        int acc;
        beat_ready = 1'b1;
        send_cmd(32'h102, 8'd2, 3'd1, 2'b00, acc);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (beat_valid !== 1'b1 || beat_addr !== 32'h102 || beat_strb !== 4'hC ||
                beat_idx !== 8'(i) || beat_last !== (i == 2)) begin
                n_fail++;
                $display("FAIL fixed_beat%0d: got v=%b a=%h s=%h idx=%0d l=%b expected v=1 a=00000102 s=c idx=%0d l=%b",
                         i, beat_valid, beat_addr, beat_strb, beat_idx, beat_last, i, (i == 2));
            end
            tick();
        end
        n_checks++;
        if (beat_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fixed_end: got v=%b expected 0", beat_valid);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] ia [3];
        logic [7:0]  il [3];
        logic [2:0]  is [3];
        logic [1:0]  ib [3];
        int acc;
        ia = '{32'hFF8, 32'h40, 32'h0};
        il = '{8'd3, 8'd2, 8'd0};
        is = '{3'd2, 3'd2, 3'd3};
        ib = '{2'b01, 2'b10, 2'b01};
        beat_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send_cmd(ia[k], il[k], is[k], ib[k], acc);
            n_checks++;
            if (cmd_err !== 1'b1 || beat_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL illegal%0d_err: got err=%b v=%b expected err=1 v=0", k, cmd_err, beat_valid);
            end
            tick();
            n_checks++;
            if (cmd_err !== 1'b0 || beat_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL illegal%0d_after: got err=%b v=%b expected err=0 v=0", k, cmd_err, beat_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        int acc;
        beat_ready = 1'b0;
        send_cmd(32'h0, 8'd1, 3'd2, 2'b01, acc);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (beat_valid !== 1'b1 || beat_addr !== 32'h0 || beat_strb !== 4'hF ||
                beat_idx !== 8'd0 || beat_last !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v=%b a=%h s=%h idx=%0d l=%b expected v=1 a=00000000 s=f idx=0 l=0",
                         k, beat_valid, beat_addr, beat_strb, beat_idx, beat_last);
            end
            if (k == 3) beat_ready = 1'b1;
            tick();
        end
        n_checks++;
        if (beat_valid !== 1'b1 || beat_addr !== 32'h4 || beat_idx !== 8'd1 || beat_last !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_beat1: got v=%b a=%h idx=%0d l=%b expected v=1 a=00000004 idx=1 l=1",
                     beat_valid, beat_addr, beat_idx, beat_last);
        end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        int acc;
        beat_ready = 1'b1;
        send_cmd(32'h0, 8'd7, 3'd2, 2'b01, acc);
        tick();
        tick();
        n_checks++;
        if (beat_valid !== 1'b1 || beat_idx !== 8'd2 || beat_addr !== 32'h8) begin
            n_fail++;
            $display("FAIL rst_mid_beat2: got v=%b idx=%0d a=%h expected v=1 idx=2 a=00000008",
                     beat_valid, beat_idx, beat_addr);
        end
        areset = 1'b1;
        tick();
        n_checks++;
        if (beat_valid !== 1'b0 || beat_idx !== 8'd0 || cmd_ready !== 1'b0 || beat_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid_state: got v=%b idx=%0d rdy=%b a=%h expected v=0 idx=0 rdy=0 a=00000000",
                     beat_valid, beat_idx, cmd_ready, beat_addr);
        end
        areset = 1'b0;
        tick();
        n_checks++;
        if (cmd_ready !== 1'b1 || beat_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_release: got rdy=%b v=%b expected rdy=1 v=0", cmd_ready, beat_valid);
        end
        tick();
        tick();
        n_checks++;
        if (beat_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_no_beats: got v=%b expected 0", beat_valid);
        end
    endtask

    task automatic test_back_to_back();
        int acc0, acc1;
        beat_ready = 1'b1;
        send_cmd(32'h20, 8'd0, 3'd2, 2'b01, acc0);
        n_checks++;
        if (beat_valid !== 1'b1 || beat_last !== 1'b1 || beat_idx !== 8'd0 ||
            beat_addr !== 32'h20 || beat_strb !== 4'hF) begin
            n_fail++;
            $display("FAIL b2b_single: got v=%b l=%b idx=%0d a=%h s=%h expected v=1 l=1 idx=0 a=00000020 s=f",
                     beat_valid, beat_last, beat_idx, beat_addr, beat_strb);
        end
        tick();
        send_cmd(32'h41, 8'd1, 3'd1, 2'b01, acc1);
        n_checks++;
        if (acc1 - acc0 !== 3) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d expected 3", acc1 - acc0);
        end
        n_checks++;
        if (beat_addr !== 32'h41 || beat_strb !== 4'h2 || beat_last !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second_b0: got a=%h s=%h l=%b expected a=00000041 s=2 l=0",
                     beat_addr, beat_strb, beat_last);
        end
        tick();
        n_checks++;
        if (beat_addr !== 32'h42 || beat_strb !== 4'hC || beat_last !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second_b1: got a=%h s=%h l=%b expected a=00000042 s=c l=1",
                     beat_addr, beat_strb, beat_last);
        end
        tick();
    endtask

    initial begin
        areset     = 1'b1;
        cmd_valid  = 1'b0;
        cmd_addr   = 32'h0;
        cmd_len    = 8'h0;
        cmd_size   = 3'd0;
        cmd_burst  = 2'b00;
        beat_ready = 1'b0;
        #1;
        test_reset();
        test_incr();
        test_wrap();
        test_fixed();
        test_illegal();
        test_backpressure();
        test_reset_mid_burst();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
